ddr2_local_master: RTL

- User-side master that drives the DDR2 controller's local (Avalon-style burst) interface; it is the initiator for that interface, which is the responder.
- Accepts read/write burst commands and write data from a client, issues them as local bursts, and tracks outstanding read beats with a credit counter.
- Returns read data to the client in order.
- Sits between packet-buffer logic and the DDR2 controller top, in the phy_clk domain.

---
 rtl/ddr2_local_master_if.sv | 48 ++++
 rtl/ddr2_local_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ddr2_local_master_if.sv
// Client-side and DDR2-local-side signals of the local master.
// The master modport is the local master's view; slave is the environment's view.
interface ddr2_local_master_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              cmd_err;
  logic              rd_underflow;
  logic              local_init_done;
  logic              local_ready;
  logic [ADDR_W-1:0] local_address;
  logic [3:0]        local_size;
  logic              local_burstbegin;
  logic              local_read_req;
  logic              local_write_req;
  logic [DATA_W-1:0] local_wdata;
  logic [BE_W-1:0]   local_be;
  logic [DATA_W-1:0] local_rdata;
  logic              local_rdata_valid;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_be,
    input  local_init_done, local_ready, local_rdata, local_rdata_valid,
    output cmd_ready, wr_ready, rd_valid, rd_data, cmd_err, rd_underflow,
    output local_address, local_size, local_burstbegin, local_read_req,
    output local_write_req, local_wdata, local_be
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_be,
    output local_init_done, local_ready, local_rdata, local_rdata_valid,
    input  cmd_ready, wr_ready, rd_valid, rd_data, cmd_err, rd_underflow,
    input  local_address, local_size, local_burstbegin, local_read_req,
    input  local_write_req, local_wdata, local_be
  );
endinterface

// File: rtl/ddr2_local_master.sv
// Client-facing master for the DDR2 controller local burst interface: issues
// read/write bursts, reserves read credit at accept time, returns read data.
module ddr2_local_master #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int MAX_BURST    = 4,
  parameter int MAX_RD_BEATS = 32
) (
  input logic                 phy_clk,
  input logic                 reset_phy_clk,
  ddr2_local_master_if.master bus
);
  localparam int CNT_W = $clog2(MAX_RD_BEATS + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] MAX_RD_L    = SUM_W'(MAX_RD_BEATS);
  localparam logic [3:0]       MAX_BURST_L = 4'(MAX_BURST);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_BURST = 2'd1, RD_REQ = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        size_q, size_d;
  logic              err_q, err_d;
  logic              uflow_q, uflow_d;
  logic              rv_q;
  logic [DATA_W-1:0] rdata_q;

  logic              cmd_ready_s, wr_ready_s, wreq_s, rreq_s, bb_s;
  logic [DATA_W-1:0] wdata_s;
  logic [BE_W-1:0]   be_s;
  logic              credit_ok_s, accept_s, len_bad_s, wr_fire_s, last_beat_s, dec_s;
  logic [SUM_W-1:0]  reserve_s, cnt_sum_s;

  assign credit_ok_s = ({1'b0, rd_cnt_q} + SUM_W'(bus.cmd_len)) <= MAX_RD_L;
  assign accept_s    = bus.cmd_valid & cmd_ready_s;
  assign len_bad_s   = (bus.cmd_len == 4'd0) | (bus.cmd_len > MAX_BURST_L);
  assign wr_fire_s   = (state_q == WR_BURST) & bus.wr_valid & bus.local_ready;
  assign last_beat_s = wr_fire_s & (beat_cnt_q == 4'd1);
  // A return beat only consumes credit when some is actually reserved.
  assign dec_s       = bus.local_rdata_valid & (rd_cnt_q != {CNT_W{1'b0}});
  assign cnt_sum_s   = {1'b0, rd_cnt_q} + reserve_s - SUM_W'(dec_s);

  always_ff @(posedge phy_clk or posedge reset_phy_clk) begin
    if (reset_phy_clk) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s & ~len_bad_s) begin
          state_d = bus.cmd_write ? WR_BURST : RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (last_beat_s) state_d = IDLE;
        else             state_d = WR_BURST;
      end
      RD_REQ: begin
        if (bus.local_ready) state_d = IDLE;
        else                 state_d = RD_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset is folded into cmd_ready so it reads 0 while reset is held.
  always_comb begin
    cmd_ready_s = 1'b0;
    wr_ready_s  = 1'b0;
    wreq_s      = 1'b0;
    rreq_s      = 1'b0;
    bb_s        = 1'b0;
    wdata_s     = {DATA_W{1'b0}};
    be_s        = {BE_W{1'b0}};
    case (state_q)
      IDLE: begin
        cmd_ready_s = ~reset_phy_clk & bus.local_init_done & (bus.cmd_write | credit_ok_s);
      end
      WR_BURST: begin
        wr_ready_s = bus.local_ready;
        wreq_s     = bus.wr_valid;
        bb_s       = first_q;
        wdata_s    = bus.wr_data;
        be_s       = bus.wr_be;
      end
      RD_REQ: begin
        rreq_s = 1'b1;
        bb_s   = 1'b1;
      end
      default: cmd_ready_s = 1'b0;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    first_d    = first_q;
    addr_d     = addr_q;
    size_d     = size_q;
    err_d      = err_q;
    reserve_s  = {SUM_W{1'b0}};
    if (accept_s & len_bad_s) begin
      err_d = 1'b1;
    end else if (accept_s) begin
      addr_d     = bus.cmd_addr;
      size_d     = bus.cmd_len;
      beat_cnt_d = bus.cmd_len;
      first_d    = bus.cmd_write;
      reserve_s  = bus.cmd_write ? {SUM_W{1'b0}} : SUM_W'(bus.cmd_len);
    end else if (wr_fire_s) begin
      beat_cnt_d = beat_cnt_q - 4'd1;
      first_d    = 1'b0;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    rd_cnt_d = cnt_sum_s[CNT_W-1:0];
    uflow_d  = uflow_q | (bus.local_rdata_valid & (rd_cnt_q == {CNT_W{1'b0}}));
  end

  always_ff @(posedge phy_clk or posedge reset_phy_clk) begin
    if (reset_phy_clk) begin
      rd_cnt_q   <= {CNT_W{1'b0}};
      beat_cnt_q <= 4'd0;
      first_q    <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      size_q     <= 4'd0;
      err_q      <= 1'b0;
      uflow_q    <= 1'b0;
      rv_q       <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      err_q      <= err_d;
      uflow_q    <= uflow_d;
      rv_q       <= bus.local_rdata_valid;
      rdata_q    <= bus.local_rdata;
    end
  end

  assign bus.cmd_ready        = cmd_ready_s;
  assign bus.wr_ready         = wr_ready_s;
  assign bus.local_write_req  = wreq_s;
  assign bus.local_read_req   = rreq_s;
  assign bus.local_burstbegin = bb_s;
  assign bus.local_wdata      = wdata_s;
  assign bus.local_be         = be_s;
  assign bus.local_address    = addr_q;
  assign bus.local_size       = size_q;
  assign bus.cmd_err          = err_q;
  assign bus.rd_underflow     = uflow_q;
  assign bus.rd_valid         = rv_q;
  assign bus.rd_data          = rdata_q;
endmodule
